// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load-store unit: address-map regions,
// page bases and byte-lane utilities.
package lsu_pkg;

  typedef enum logic [3:0] {
    REG_RAM,
    REG_LEDR,
    REG_LEDG,
    REG_HEX,
    REG_LCD,
    REG_SW,
    REG_BTN,
    REG_BTN_EDGE,
    REG_NONE
  } region_e;

  localparam logic [19:0] PAGE_RAM      = 20'h00000;
  localparam logic [19:0] PAGE_LEDR     = 20'h10000;
  localparam logic [19:0] PAGE_LEDG     = 20'h10001;
  localparam logic [19:0] PAGE_HEX      = 20'h10002;
  localparam logic [19:0] PAGE_LCD      = 20'h10004;
  localparam logic [19:0] PAGE_SW       = 20'h10010;
  localparam logic [19:0] PAGE_BTN      = 20'h10011;
  localparam logic [19:0] PAGE_BTN_EDGE = 20'h10012;

  function automatic logic [31:0] mask_to_bitmask(input logic [3:0] mask);
    logic [31:0] bm;
    for (int b = 0; b < 4; b++) bm[8*b +: 8] = {8{mask[b]}};
    return bm;
  endfunction

  // Byte accesses may use any lane; halfwords need an even address, words a 4-aligned one.
  function automatic logic is_aligned(input logic [1:0] addr, input logic [3:0] mask);
    case (mask)
      4'b0001, 4'b0010, 4'b0100, 4'b1000: return 1'b1;
      4'b0011, 4'b1100:                   return !addr[0];
      4'b1111:                            return addr == 2'b00;
      default:                            return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] width_mask(input int bits);
    if (bits >= 32) return '1;
    if (bits <= 0) return '0;
    return (32'd1 << bits) - 32'd1;
  endfunction

  function automatic logic [31:0] merge_lanes(input logic [31:0] old_v, input logic [31:0] new_v,
                                              input logic [31:0] m);
    return (old_v & ~m) | (new_v & m);
  endfunction

endpackage

// File: rtl/sync_edge_capture.sv
// Multi-stage synchroniser for asynchronous inputs, also flagging
// one-cycle rising edges of the synchronised level.
module sync_edge_capture #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] async_in,
  output logic [WIDTH-1:0] level,
  output logic [WIDTH-1:0] rise
);

  logic [WIDTH-1:0] stage_q [STAGES];
  logic [WIDTH-1:0] prev_q;

  // NOTE: non-blocking assignments make every stage sample the previous stage's old value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < STAGES; s++) stage_q[s] <= '0;
      prev_q <= '0;
    end else begin
      stage_q[0] <= async_in;
      for (int s = 1; s < STAGES; s++) stage_q[s] <= stage_q[s-1];
      prev_q <= stage_q[STAGES-1];
    end
  end

  assign level = stage_q[STAGES-1];
  assign rise  = level & ~prev_q;

endmodule

// File: rtl/lsu_mmio_v2.sv
// Load-store unit: data RAM plus memory-mapped LEDs, hex digits, LCD,
// switches and buttons, with registered 1-cycle loads and misalignment faults.
module lsu_mmio_v2
  import lsu_pkg::*;
#(
  parameter int MEM_ADDR_W  = 11,
  parameter int NUM_HEX     = 8,
  parameter int LEDR_W      = 32,
  parameter int LEDG_W      = 32,
  parameter int SW_W        = 32,
  parameter int BTN_W       = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_req,
  input  logic                 i_wren,
  input  logic [31:0]          i_addr,
  input  logic [31:0]          i_stData,
  input  logic [3:0]           i_mask,
  input  logic [SW_W-1:0]      i_ph_sw,
  input  logic [BTN_W-1:0]     i_ph_button,
  output logic [31:0]          o_ldData,
  output logic                 o_ld_valid,
  output logic                 o_fault,
  output logic [LEDR_W-1:0]    o_ph_ledr,
  output logic [LEDG_W-1:0]    o_ph_ledg,
  output logic [7*NUM_HEX-1:0] o_ph_seg,
  output logic [31:0]          o_ph_lcd
);

  localparam int HEX_WORDS = (NUM_HEX + 3) / 4;
  localparam int RAM_WORDS = 2 ** (MEM_ADDR_W - 2);
  localparam logic [31:0] LEDR_M = width_mask(LEDR_W);
  localparam logic [31:0] LEDG_M = width_mask(LEDG_W);

  logic [19:0] page;
  logic [9:0]  word;
  region_e     region;
  logic        aligned, st_en, ld_en;
  logic [31:0] bm, rd_word;

  assign page    = i_addr[31:12];
  assign word    = i_addr[11:2];
  assign aligned = is_aligned(i_addr[1:0], i_mask);
  assign bm      = mask_to_bitmask(i_mask);
  assign st_en   = i_req & i_wren & aligned;
  assign ld_en   = i_req & ~i_wren & aligned;

  // NOTE: defaulting every always_comb output first keeps it free of inferred latches.
  always_comb begin
    region = REG_NONE;
    case (page)
      PAGE_RAM:      if ({20'd0, i_addr[11:0]} < (32'd1 << MEM_ADDR_W)) region = REG_RAM;
      PAGE_LEDR:     if (word == '0) region = REG_LEDR;
      PAGE_LEDG:     if (word == '0) region = REG_LEDG;
      PAGE_HEX:      if (32'(word) < HEX_WORDS) region = REG_HEX;
      PAGE_LCD:      if (word == '0) region = REG_LCD;
      PAGE_SW:       if (word == '0) region = REG_SW;
      PAGE_BTN:      if (word == '0) region = REG_BTN;
      PAGE_BTN_EDGE: if (word == '0) region = REG_BTN_EDGE;
      default: ;
    endcase
  end

  logic [SW_W-1:0]  sw_sync, sw_rise_unused;
  logic [BTN_W-1:0] btn_sync, btn_rise, btn_clr;

  sync_edge_capture #(.WIDTH(SW_W), .STAGES(SYNC_STAGES)) u_sw_sync (
    .clk(i_clk), .rst(i_reset), .async_in(i_ph_sw), .level(sw_sync), .rise(sw_rise_unused)
  );

  sync_edge_capture #(.WIDTH(BTN_W), .STAGES(SYNC_STAGES)) u_btn_sync (
    .clk(i_clk), .rst(i_reset), .async_in(i_ph_button), .level(btn_sync), .rise(btn_rise)
  );

  assign btn_clr = (st_en && region == REG_BTN_EDGE) ? BTN_W'(i_stData & bm) : '0;

  logic [31:0]             ledr_q, ledg_q, lcd_q;
  logic [HEX_WORDS*32-1:0] hex_q;
  logic [BTN_W-1:0]        edge_q;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      ledr_q <= '0;
      ledg_q <= '0;
      lcd_q  <= '0;
      hex_q  <= '0;
      edge_q <= '0;
    end else begin
      // A new edge overrides a simultaneous clear of the same bit.
      edge_q <= (edge_q & ~btn_clr) | btn_rise;
      if (st_en) begin
        case (region)
          REG_LEDR: ledr_q <= merge_lanes(ledr_q, i_stData, bm & LEDR_M);
          REG_LEDG: ledg_q <= merge_lanes(ledg_q, i_stData, bm & LEDG_M);
          REG_LCD:  lcd_q  <= merge_lanes(lcd_q, i_stData, bm);
          REG_HEX:
            for (int w = 0; w < HEX_WORDS; w++)
              if (word == 10'(w))
                hex_q[w*32 +: 32] <= merge_lanes(hex_q[w*32 +: 32], i_stData,
                                                 bm & width_mask(NUM_HEX*8 - w*32));
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    rd_word = '0;
    case (region)
      REG_LEDR:     rd_word = ledr_q;
      REG_LEDG:     rd_word = ledg_q;
      REG_LCD:      rd_word = lcd_q;
      REG_HEX:
        for (int w = 0; w < HEX_WORDS; w++)
          if (word == 10'(w)) rd_word = hex_q[w*32 +: 32];
      REG_SW:       rd_word = 32'(sw_sync);
      REG_BTN:      rd_word = 32'(btn_sync);
      REG_BTN_EDGE: rd_word = 32'(edge_q);
      default: ;
    endcase
  end

  logic [31:0]                mem [RAM_WORDS];
  logic [31:0]                ram_q;
  logic [MEM_ADDR_W-3:0]      ram_idx;
  assign ram_idx = i_addr[MEM_ADDR_W-1:2];

  // NOTE: the RAM array and its read register have no reset so they map onto block RAM.
  always_ff @(posedge i_clk) begin
    if (st_en && region == REG_RAM)
      for (int b = 0; b < 4; b++)
        if (i_mask[b]) mem[ram_idx][8*b +: 8] <= i_stData[8*b +: 8];
    if (ld_en && region == REG_RAM) ram_q <= mem[ram_idx];
  end

  logic        ld_valid_q, fault_q, ld_ram_q;
  logic [31:0] ld_bm_q, periph_q;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      ld_valid_q <= 1'b0;
      fault_q    <= 1'b0;
      ld_ram_q   <= 1'b0;
      ld_bm_q    <= '0;
      periph_q   <= '0;
    end else begin
      ld_valid_q <= i_req & ~i_wren;
      fault_q    <= i_req & ~aligned;
      if (i_req && !i_wren) begin
        ld_ram_q <= ld_en && region == REG_RAM;
        ld_bm_q  <= bm;
        periph_q <= ld_en ? (rd_word & bm) : '0;
      end
    end
  end

  assign o_ldData   = ld_ram_q ? (ram_q & ld_bm_q) : periph_q;
  assign o_ld_valid = ld_valid_q;
  assign o_fault    = fault_q;
  assign o_ph_ledr  = ledr_q[LEDR_W-1:0];
  assign o_ph_ledg  = ledg_q[LEDG_W-1:0];
  assign o_ph_lcd   = lcd_q;

  for (genvar k = 0; k < NUM_HEX; k++) begin : g_seg
    assign o_ph_seg[7*k +: 7] = hex_q[8*k +: 7];
  end

endmodule

// File: tb/tb_lsu_mmio_v2.sv
// Scoreboard bench for lsu_mmio_v2 at default parameters: per-feature tasks
// queue expected load/fault results, a monitor compares them each cycle.
module tb_lsu_mmio_v2;

  logic        i_clk = 1'b0;
  logic        i_reset = 1'b1;
  logic        i_req = 1'b0, i_wren = 1'b0;
  logic [31:0] i_addr = '0, i_stData = '0;
  logic [3:0]  i_mask = '0;
  logic [31:0] i_ph_sw = '0, i_ph_button = '0;
  logic [31:0] o_ldData, o_ph_ledr, o_ph_ledg, o_ph_lcd;
  logic        o_ld_valid, o_fault;
  logic [55:0] o_ph_seg;

  lsu_mmio_v2 dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_req(i_req), .i_wren(i_wren), .i_addr(i_addr),
    .i_stData(i_stData), .i_mask(i_mask), .i_ph_sw(i_ph_sw), .i_ph_button(i_ph_button),
    .o_ldData(o_ldData), .o_ld_valid(o_ld_valid), .o_fault(o_fault), .o_ph_ledr(o_ph_ledr),
    .o_ph_ledg(o_ph_ledg), .o_ph_seg(o_ph_seg), .o_ph_lcd(o_ph_lcd)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic        valid;
    logic [31:0] data;
    logic        fault;
    logic [31:0] addr;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0, failures = 0;
  logic        mon_en = 1'b0;
  logic [31:0] exp_hold = '0;

  // Monitor: one queued expectation per accepted request; idle cycles expect no strobes.
  always begin
    exp_t e;
    @(posedge i_clk);
    #2;
    if (mon_en) begin
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checks++;
        if (o_ld_valid !== e.valid) begin
          failures++;
          $display("FAIL sb_valid addr=%08h got=%0b exp=%0b", e.addr, o_ld_valid, e.valid);
        end
        checks++;
        if (o_fault !== e.fault) begin
          failures++;
          $display("FAIL sb_fault addr=%08h got=%0b exp=%0b", e.addr, o_fault, e.fault);
        end
        if (e.valid) exp_hold = e.data;
        checks++;
        if (o_ldData !== exp_hold) begin
          failures++;
          $display("FAIL sb_data addr=%08h got=%08h exp=%08h", e.addr, o_ldData, exp_hold);
        end
      end else begin
        checks++;
        if (o_ld_valid !== 1'b0 || o_fault !== 1'b0 || o_ldData !== exp_hold) begin
          failures++;
          $display("FAIL idle valid=%0b fault=%0b data=%08h exp 0/0/%08h",
                   o_ld_valid, o_fault, o_ldData, exp_hold);
        end
      end
    end
  end

  task automatic access(input logic wr, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] m, input logic [31:0] ed, input logic ef);
    exp_t e;
    @(negedge i_clk);
    i_req = 1'b1; i_wren = wr; i_addr = a; i_stData = d; i_mask = m;
    e.valid = !wr; e.data = ed; e.fault = ef; e.addr = a;
    sb.push_back(e);
    @(posedge i_clk);
    #1;
    i_req = 1'b0; i_wren = 1'b0;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m,
                       input logic ef);
    access(1'b1, a, d, m, 32'h0, ef);
  endtask

  task automatic load(input logic [31:0] a, input logic [3:0] m, input logic [31:0] ed,
                      input logic ef);
    access(1'b0, a, 32'h0, m, ed, ef);
  endtask

  task automatic test_reset;
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    checks++;
    if ({o_ld_valid, o_fault} !== 2'b00 || o_ldData !== 32'h0) begin
      failures++;
      $display("FAIL reset_strobes valid=%0b fault=%0b data=%08h exp 0", o_ld_valid, o_fault, o_ldData);
    end
    checks++;
    if (o_ph_ledr !== 32'h0 || o_ph_ledg !== 32'h0 || o_ph_seg !== 56'h0 || o_ph_lcd !== 32'h0) begin
      failures++;
      $display("FAIL reset_periph ledr=%08h ledg=%08h seg=%014h lcd=%08h exp 0",
               o_ph_ledr, o_ph_ledg, o_ph_seg, o_ph_lcd);
    end
    i_reset = 1'b0;
    mon_en = 1'b1;
  endtask

  task automatic test_leds;
    store(32'h1000_0000, 32'hDEAD_BEEF, 4'b1111, 1'b0);
    #1;
    checks++;
    if (o_ph_ledr !== 32'hDEAD_BEEF) begin
      failures++;
      $display("FAIL ledr_out got=%08h exp=%08h", o_ph_ledr, 32'hDEAD_BEEF);
    end
    load(32'h1000_0000, 4'b1111, 32'hDEAD_BEEF, 1'b0);
    load(32'h1000_0002, 4'b0100, 32'h00AD_0000, 1'b0);
    store(32'h1000_0004, 32'hFFFF_FFFF, 4'b1111, 1'b0);
    load(32'h1000_0004, 4'b1111, 32'h0, 1'b0);
    #1;
    checks++;
    if (o_ph_ledr !== 32'hDEAD_BEEF) begin
      failures++;
      $display("FAIL ledr_word1_ignored got=%08h exp=%08h", o_ph_ledr, 32'hDEAD_BEEF);
    end
    store(32'h1000_1000, 32'h0000_00A5, 4'b0001, 1'b0);
    #1;
    checks++;
    if (o_ph_ledg !== 32'h0000_00A5) begin
      failures++;
      $display("FAIL ledg_out got=%08h exp=%08h", o_ph_ledg, 32'h0000_00A5);
    end
    load(32'h1000_1000, 4'b1111, 32'h0000_00A5, 1'b0);
  endtask

  task automatic test_ram;
    store(32'h0000_0100, 32'hCAFE_F00D, 4'b1111, 1'b0);
    store(32'h0000_0102, 32'h1234_0000, 4'b1100, 1'b0);
    load(32'h0000_0100, 4'b1111, 32'h1234_F00D, 1'b0);
    load(32'h0000_0100, 4'b0001, 32'h0000_000D, 1'b0);
    load(32'h0000_0101, 4'b0010, 32'h0000_F000, 1'b0);
    store(32'h0000_0000, 32'h1111_1111, 4'b1111, 1'b0);
    store(32'h0000_0800, 32'h2222_2222, 4'b1111, 1'b0);
    load(32'h0000_0000, 4'b1111, 32'h1111_1111, 1'b0);
    load(32'h0000_0800, 4'b1111, 32'h0, 1'b0);
  endtask

  task automatic test_hex;
    store(32'h1000_2004, 32'h7F3F_0640, 4'b1111, 1'b0);
    #1;
    checks++;
    if (o_ph_seg[34:28] !== 7'h40) begin
      failures++;
      $display("FAIL hex_digit4 got=%02h exp=%02h", o_ph_seg[34:28], 7'h40);
    end
    checks++;
    if (o_ph_seg !== {7'h7F, 7'h3F, 7'h06, 7'h40, 28'h0}) begin
      failures++;
      $display("FAIL hex_seg got=%014h exp=%014h", o_ph_seg, {7'h7F, 7'h3F, 7'h06, 7'h40, 28'h0});
    end
    store(32'h1000_2000, 32'h0000_00FF, 4'b0001, 1'b0);
    #1;
    checks++;
    if (o_ph_seg[6:0] !== 7'h7F) begin
      failures++;
      $display("FAIL hex_digit0 got=%02h exp=%02h", o_ph_seg[6:0], 7'h7F);
    end
    load(32'h1000_2000, 4'b1111, 32'h0000_00FF, 1'b0);
    load(32'h1000_2004, 4'b1111, 32'h7F3F_0640, 1'b0);
    load(32'h1000_2008, 4'b1111, 32'h0, 1'b0);
  endtask

  task automatic test_misaligned;
    store(32'h1000_4000, 32'h55AA_55AA, 4'b1111, 1'b0);
    store(32'h1000_4001, 32'h0000_FFFF, 4'b0011, 1'b1);
    #1;
    checks++;
    if (o_ph_lcd !== 32'h55AA_55AA) begin
      failures++;
      $display("FAIL lcd_misaligned_store got=%08h exp=%08h", o_ph_lcd, 32'h55AA_55AA);
    end
    load(32'h0000_0102, 4'b1111, 32'h0, 1'b1);
    load(32'h1000_4002, 4'b1111, 32'h0, 1'b1);
    load(32'h1000_4002, 4'b1100, 32'h55AA_0000, 1'b0);
    load(32'h1000_4003, 4'b1000, 32'h5500_0000, 1'b0);
  endtask

  task automatic test_sw;
    i_ph_sw = 32'h1357_2468;
    repeat (4) @(posedge i_clk);
    load(32'h1001_0000, 4'b1111, 32'h1357_2468, 1'b0);
    store(32'h1001_0000, 32'hFFFF_FFFF, 4'b1111, 1'b0);
    load(32'h1001_0000, 4'b0010, 32'h0000_2400, 1'b0);
  endtask

  task automatic test_btn;
    @(negedge i_clk);
    i_ph_button = 32'h8;
    repeat (6) @(posedge i_clk);
    load(32'h1001_2000, 4'b1111, 32'h8, 1'b0);
    load(32'h1001_1000, 4'b1111, 32'h8, 1'b0);
    store(32'h1001_2000, 32'h8, 4'b1111, 1'b0);
    load(32'h1001_2000, 4'b1111, 32'h0, 1'b0);
    @(negedge i_clk);
    i_ph_button = 32'h0;
    repeat (6) @(posedge i_clk);
    load(32'h1001_2000, 4'b1111, 32'h0, 1'b0);
    // Rise again and land the clear on the cycle the synchronised edge is captured.
    @(negedge i_clk);
    i_ph_button = 32'h8;
    repeat (2) @(posedge i_clk);
    store(32'h1001_2000, 32'h8, 4'b1111, 1'b0);
    load(32'h1001_2000, 4'b1111, 32'h8, 1'b0);
  endtask

  task automatic test_unmapped_back_to_back;
    load(32'h2000_0000, 4'b1111, 32'h0, 1'b0);
    store(32'h0000_0200, 32'h0000_BEEF, 4'b1111, 1'b0);
    load(32'h0000_0200, 4'b1111, 32'h0000_BEEF, 1'b0);
    load(32'h1000_0000, 4'b1111, 32'hDEAD_BEEF, 1'b0);
    store(32'h0000_0204, 32'h0BAD_F00D, 4'b1111, 1'b0);
    load(32'h0000_0204, 4'b1111, 32'h0BAD_F00D, 1'b0);
    load(32'h0000_0200, 4'b0010, 32'h0000_BE00, 1'b0);
    load(32'h1000_3000, 4'b1111, 32'h0, 1'b0);
  endtask

  task automatic test_reset_inflight;
    repeat (2) @(posedge i_clk);
    mon_en = 1'b0;
    @(negedge i_clk);
    i_req = 1'b1; i_wren = 1'b0; i_addr = 32'h1000_0000; i_mask = 4'b1111;
    @(posedge i_clk);
    #1;
    i_req = 1'b0;
    checks++;
    if (o_ld_valid !== 1'b1 || o_ldData !== 32'hDEAD_BEEF) begin
      failures++;
      $display("FAIL pre_reset_load valid=%0b data=%08h exp 1/%08h", o_ld_valid, o_ldData, 32'hDEAD_BEEF);
    end
    i_reset = 1'b1;
    #1;
    checks++;
    if (o_ld_valid !== 1'b0 || o_ldData !== 32'h0 || o_fault !== 1'b0) begin
      failures++;
      $display("FAIL reset_drop valid=%0b fault=%0b data=%08h exp 0", o_ld_valid, o_fault, o_ldData);
    end
    checks++;
    if (o_ph_ledr !== 32'h0 || o_ph_ledg !== 32'h0 || o_ph_seg !== 56'h0 || o_ph_lcd !== 32'h0) begin
      failures++;
      $display("FAIL reset_periph_mid ledr=%08h ledg=%08h seg=%014h lcd=%08h exp 0",
               o_ph_ledr, o_ph_ledg, o_ph_seg, o_ph_lcd);
    end
    @(negedge i_clk);
    @(negedge i_clk);
    i_reset = 1'b0;
    sb.delete();
    exp_hold = 32'h0;
    mon_en = 1'b1;
    load(32'h1000_0000, 4'b1111, 32'h0, 1'b0);
    load(32'h1001_2000, 4'b1111, 32'h0, 1'b0);
    load(32'h0000_0100, 4'b1111, 32'h1234_F00D, 1'b0);
  endtask

  initial begin
    test_reset();
    test_leds();
    test_ram();
    test_hex();
    test_misaligned();
    test_sw();
    test_btn();
    test_unmapped_back_to_back();
    test_reset_inflight();
    repeat (3) @(posedge i_clk);
    #3;
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL sb_drain pending=%0d exp=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lsu_mmio_v2.md
Name: lsu_mmio_v2

Overview:
Parametrised load-store unit for the single-cycle/pipelined RV32 core. It decodes a 32-bit byte address into the data RAM and the memory-mapped peripherals: red/green LEDs, a hex-digit window, LCD, switches, raw buttons and a button edge-capture register. Loads are registered with a fixed 1-cycle latency and a valid strobe. Misaligned accesses are detected and faulted. Switch and button inputs pass through synchronisers.

Parameters:
MEM_ADDR_W, 11, byte-address width of data RAM (2^MEM_ADDR_W bytes, legal range 4..12)
NUM_HEX, 8, number of 7-segment digits (1..16)
LEDR_W, 32, red LED width (1..32)
LEDG_W, 32, green LED width (1..32)
SW_W, 32, switch input width (1..32)
BTN_W, 32, button input width (1..32)
SYNC_STAGES, 2, synchroniser depth for sw/button (>=2)

Ports:
i_clk  in  1  clock
i_reset  in  1  asynchronous active-high reset
i_req  in  1  access valid this cycle
i_wren  in  1  1=store, 0=load (qualified by i_req)
i_addr  in  32  byte address
i_stData  in  32  store data, lane-aligned
i_mask  in  4  byte-lane enables: 0001/0010/0100/1000, 0011/1100, or 1111
i_ph_sw  in  SW_W  switches (asynchronous)
i_ph_button  in  BTN_W  buttons (asynchronous, active-high)
o_ldData  out  32  load data, lane-aligned, unmasked lanes zero
o_ld_valid  out  1  load data valid
o_fault  out  1  misaligned-access pulse, same cycle as o_ld_valid timing
o_ph_ledr  out  LEDR_W  red LEDs
o_ph_ledg  out  LEDG_W  green LEDs
o_ph_seg  out  7*NUM_HEX  digit k occupies bits [7k+6:7k]
o_ph_lcd  out  32  LCD register

Behaviour:
- Reset (async, i_reset=1): all peripheral registers, edge-capture register, synchronisers, o_ld_valid, o_fault and o_ldData go to 0. RAM contents are not reset. Any in-flight load is dropped.
- Address map (i_addr[31:12]):
  - 0x00000: RAM when i_addr[11:0] < 2^MEM_ADDR_W, else unmapped.
  - 0x10000: LEDR.
  - 0x10001: LEDG.
  - 0x10002: HEX window. Digit k is at byte offset k; bit 7 of each byte is stored and read back but not driven out.
  - 0x10004: LCD.
  - 0x10010: SW (read-only).
  - 0x10011: BTN raw (read-only).
  - 0x10012: BTN edge capture (read; write-1-to-clear).
  - Any other page is unmapped.
- Register window offset: the word is selected by i_addr[11:2]. For LEDR/LEDG/LCD/SW/BTN only word 0 exists; other words are unmapped. HEX words 0..ceil(NUM_HEX/4)-1 exist. Bytes beyond the parameter width read 0 and ignore writes.
- Alignment: legal when popcount(mask)=1, or mask is 0011/1100, or mask is 1111; the lane(s) are taken as given. Halfword with i_addr[0]=1, or word with i_addr[1:0]!=0, is misaligned. A misaligned access performs no write and returns 0 data. o_fault=1 for one cycle, at cycle N+1 for a request accepted at edge N, for loads and stores alike.
- Stores: committed at the accepting clock edge, per enabled lane. Stores to read-only or unmapped addresses are silently ignored (no fault).
- Loads: data for the request at edge N appears on o_ldData with o_ld_valid=1 during cycle N+1 (registered; RAM is synchronous read). Unmapped loads return 0 with valid=1. A new request is accepted every cycle; there is no back-pressure.
- Store followed by a load to the same address on the next cycle returns the new data.
- SW/BTN are read from the SYNC_STAGES-deep synchronised value.
- Edge capture:
  - Bit i sets on a synchronised 0→1 transition of button i.
  - A store with data bit i = 1 on an enabled lane clears bit i.
  - Simultaneous set and clear on the same bit: set wins.
- o_ldData is held between loads; o_ld_valid is 0 in cycles after non-load requests or idle cycles.

Decomposition:
- Package lsu_pkg:
  - region enum (REG_RAM, REG_LEDR, REG_LEDG, REG_HEX, REG_LCD, REG_SW, REG_BTN, REG_BTN_EDGE, REG_NONE);
  - page base constants;
  - a function mask_to_bitmask(mask) returning the 32-bit lane mask;
  - a function is_aligned(addr[1:0], mask).
- Sub-module sync_edge_capture, parameterised by WIDTH and STAGES. Outputs the synchronised level and the rising-edge pulse; used once for SW (level only) and once for BTN.

Test Plan:
- Reset held, then SW word store 0xDEADBEEF to 0x1000_0000 mask 1111 -> o_ph_ledr=0xDEADBEEF next cycle; load returns 0xDEADBEEF with o_ld_valid=1 at N+1.
- RAM store 0x1234 at 0x0000_0102 mask 1100, immediately load word at 0x0000_0100 -> o_ldData=0x1234xxxx upper half matches, lower lanes unchanged; then load with mask 0001 -> upper lanes 0.
- NUM_HEX=8: store 0x7F3F0640 at 0x1000_2004 -> digits 4..7 = 0x40,0x06,0x3F,0x7F; o_ph_seg[34:28]=7'h40.
- Word load at 0x0000_0102 -> o_fault=1 and o_ldData=0 at N+1; halfword store at 0x1000_4001 -> LCD unchanged, o_fault pulse.
- Button 3 rises (held >SYNC_STAGES+1 cycles) -> edge reg bit3=1 and raw reads 0x8; store 0x8 to 0x1001_2000 -> bit3 cleared. A repeat clear in the same cycle as a new edge leaves bit3=1.
- Load to 0x2000_0000 -> o_ldData=0 with o_ld_valid=1, o_fault=0. Assert i_reset during a pending load -> o_ld_valid=0, all LED/seg/LCD outputs 0.
